result_demux: RTL and testbench

RESULT_DEMUX -- requirements
Module: result_demux

---
 rtl/result_demux_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/result_demux.sv | 106 ++++++++++
 tb/tb_result_demux.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/result_demux_pkg.sv
// Shared definitions for the result demultiplexer: destination encoding,
// control decode and the default data width.
package result_demux_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        DEST0 = 2'd0,
        DEST1 = 2'd1,
        DEST2 = 2'd2
    } dest_t;

    // control2 dominates, so {control1, control2} = 01 and 11 both select DEST2
    function automatic dest_t decode_dest(input logic control1, input logic control2);
        if (control2) begin
            return DEST2;
        end
        if (control1) begin
            return DEST1;
        end
        return DEST0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy; full/empty come from the
// occupancy counter, pointers wrap modulo DEPTH (DEPTH is a power of two).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occupancy;
    logic             do_push;
    logic             do_pop;

    assign full    = (occupancy == OCC_W'(DEPTH));
    assign empty   = (occupancy == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/result_demux.sv
// Routes queued words to one of three destinations chosen by the control
// bits captured with each word, in strict acceptance order.
module result_demux
    import result_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             control1,
    input  logic             control2,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    output logic             out1_valid,
    output logic             out2_valid,
    input  logic             out0_ready,
    input  logic             out1_ready,
    input  logic             out2_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic [WIDTH-1:0] out1_data,
    output logic [WIDTH-1:0] out2_data,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1,
    output logic [CNT_W-1:0] count2,
    output logic             busy
);

    logic [WIDTH+1:0] head_entry;
    logic [WIDTH-1:0] head_word;
    dest_t            head_dest;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    sync_fifo #(
        .WIDTH (WIDTH + 2),
        .DEPTH (DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data ({control1, control2, in_data}),
        .head      (head_entry),
        .full      (full),
        .empty     (empty)
    );

    // in_ready depends only on registered occupancy, never on the out*_ready inputs
    assign in_ready  = !full;
    assign push      = in_valid && in_ready;
    assign busy      = !empty;
    assign head_word = head_entry[WIDTH-1:0];
    assign head_dest = decode_dest(head_entry[WIDTH+1], head_entry[WIDTH]);

    always_comb begin
        out0_valid = 1'b0;
        out1_valid = 1'b0;
        out2_valid = 1'b0;
        out0_data  = '0;
        out1_data  = '0;
        out2_data  = '0;
        pop        = 1'b0;
        if (!empty) begin
            case (head_dest)
                DEST0: begin
                    out0_valid = 1'b1;
                    out0_data  = head_word;
                    pop        = out0_ready;
                end
                DEST1: begin
                    out1_valid = 1'b1;
                    out1_data  = head_word;
                    pop        = out1_ready;
                end
                DEST2: begin
                    out2_valid = 1'b1;
                    out2_data  = head_word;
                    pop        = out2_ready;
                end
                default: pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count0 <= '0;
            count1 <= '0;
            count2 <= '0;
        end else if (pop) begin
            case (head_dest)
                DEST0:   count0 <= count0 + CNT_W'(1);
                DEST1:   count1 <= count1 + CNT_W'(1);
                DEST2:   count2 <= count2 + CNT_W'(1);
                default: count0 <= count0;
            endcase
        end
    end

endmodule

// File: tb/tb_result_demux.sv
// Self-checking bench for result_demux: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_result_demux;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             control1;
    logic             control2;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       rdy;
    logic             out0_valid, out1_valid, out2_valid;
    logic [WIDTH-1:0] out0_data, out1_data, out2_data;
    logic [CNT_W-1:0] count0, count1, count2;
    logic             busy;

    int tests_run;
    int tests_failed;

    result_demux #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .control1   (control1),
        .control2   (control2),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out1_valid (out1_valid),
        .out2_valid (out2_valid),
        .out0_ready (rdy[0]),
        .out1_ready (rdy[1]),
        .out2_ready (rdy[2]),
        .out0_data  (out0_data),
        .out1_data  (out1_data),
        .out2_data  (out2_data),
        .count0     (count0),
        .count1     (count1),
        .count2     (count2),
        .busy       (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: a FIFO of (destination, word) plus transfer counts
    typedef struct {
        int          dest;
        logic [31:0] data;
    } item_t;

    item_t mq[$];
    int    mcnt[3];

    typedef struct {
        logic        v;
        logic        c1;
        logic        c2;
        logic [31:0] d;
        logic [2:0]  rdy;
        logic [2:0]  ev;
        logic        eir;
        logic        ebusy;
        logic [31:0] edata;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [124:0] model_outputs();
        logic [2:0]  v;
        logic [31:0] d[3];
        v = 3'b000;
        d[0] = '0; d[1] = '0; d[2] = '0;
        if (mq.size() > 0) begin
            v[mq[0].dest] = 1'b1;
            d[mq[0].dest] = mq[0].data;
        end
        return {mq.size() < DEPTH, mq.size() > 0, v, d[2], d[1], d[0],
                8'(mcnt[2]), 8'(mcnt[1]), 8'(mcnt[0])};
    endfunction

    // One clock: predict from current inputs, advance, then compare everything
    task automatic step(input string name);
        bit    acc;
        bit    pop;
        item_t it;
        acc = in_valid && (mq.size() < DEPTH);
        pop = (mq.size() > 0) && rdy[mq[0].dest];
        it.dest = control2 ? 2 : (control1 ? 1 : 0);
        it.data = in_data;
        @(posedge clock);
        if (reset) begin
            mq.delete();
            mcnt[0] = 0; mcnt[1] = 0; mcnt[2] = 0;
        end else begin
            if (pop) begin
                mcnt[mq[0].dest] = (mcnt[mq[0].dest] + 1) % 256;
                void'(mq.pop_front());
            end
            if (acc) mq.push_back(it);
        end
        #1;
        check(name,
              {in_ready, busy, out2_valid, out1_valid, out0_valid,
               out2_data, out1_data, out0_data, count2, count1, count0},
              model_outputs());
    endtask

    task automatic drive(input logic v, input logic c1, input logic c2,
                         input logic [31:0] d, input logic [2:0] r);
        in_valid = v;
        control1 = c1;
        control2 = c2;
        in_data  = d;
        rdy      = r;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        mcnt[0] = 0; mcnt[1] = 0; mcnt[2] = 0;

        // in-order routing, stall with full queue, control 01 routed to out2
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h11111111, 3'b111, 3'b001, 1'b1, 1'b1, 32'h11111111};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h22222222, 3'b111, 3'b010, 1'b1, 1'b1, 32'h22222222};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h33333333, 3'b111, 3'b100, 1'b1, 1'b1, 32'h33333333};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h00000000, 3'b111, 3'b000, 1'b1, 1'b0, 32'h00000000};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h000000A1, 3'b101, 3'b010, 1'b1, 1'b1, 32'h000000A1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h000000A2, 3'b101, 3'b010, 1'b0, 1'b1, 32'h000000A1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h000000A3, 3'b101, 3'b010, 1'b0, 1'b1, 32'h000000A1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h000000A3, 3'b101, 3'b010, 1'b0, 1'b1, 32'h000000A1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h000000A3, 3'b111, 3'b010, 1'b1, 1'b1, 32'h000000A2};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h000000A3, 3'b111, 3'b010, 1'b1, 1'b1, 32'h000000A3};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 3'b111, 3'b000, 1'b1, 1'b0, 32'h00000000};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 32'h000000B7, 3'b011, 3'b100, 1'b1, 1'b1, 32'h000000B7};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 3'b011, 3'b100, 1'b1, 1'b1, 32'h000000B7};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 3'b011, 3'b100, 1'b1, 1'b1, 32'h000000B7};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 3'b100, 3'b000, 1'b1, 1'b0, 32'h00000000};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, 3'b000);
        step("reset0");
        step("reset1");
        reset = 1'b0;
        step("idle");
        check("idle_state", {in_ready, busy, out2_valid, out1_valid, out0_valid, count2, count1, count0},
              {1'b1, 1'b0, 3'b000, 24'h0});

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].c1, tbl[i].c2, tbl[i].d, tbl[i].rdy);
            step($sformatf("model_row%0d", i));
            check($sformatf("table_row%0d", i),
                  {out2_valid, out1_valid, out0_valid, in_ready, busy, out0_data | out1_data | out2_data},
                  {tbl[i].ev, tbl[i].eir, tbl[i].ebusy, tbl[i].edata});
            if (i == 3)
                check("counts_after_three", {count2, count1, count0}, 24'h010101);
        end
        check("counts_after_table", {count2, count1, count0}, 24'h020401);

        // 256 transfers to destination 0 from a cleared state
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, 3'b111);
        step("reset_wrap");
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'(i), 3'b111);
            step("wrap_push");
        end
        check("count0_255", {24'h0, count0}, {24'h0, 8'hFF});
        drive(1'b0, 1'b0, 1'b0, '0, 3'b111);
        step("wrap_drain");
        check("count0_wrap", {24'h0, count0, busy}, 33'h0);

        // fill with out2 stalled, then reset with traffic still offered
        drive(1'b1, 1'b0, 1'b1, 32'hDEAD0001, 3'b000);
        step("fill0");
        drive(1'b1, 1'b0, 1'b1, 32'hDEAD0002, 3'b000);
        step("fill1");
        check("full_in_ready", {31'h0, in_ready}, 32'h0);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 32'hDEAD0003, 3'b111);
        step("reset_full");
        check("after_reset", {in_ready, busy, out2_valid, out1_valid, out0_valid, count2, count1, count0},
              {1'b1, 1'b0, 3'b000, 24'h0});
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, 3'b111);
        for (int i = 0; i < 3; i++) begin
            step("post_reset_idle");
            check("no_stale", {out2_valid, out1_valid, out0_valid, out2_data}, 35'h0);
        end

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  $urandom, 3'($urandom) | (($urandom_range(0, 1) == 0) ? 3'b111 : 3'b000));
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
